mmu_access_ctrl: RTL

- Initiator side of the CU–MMU word interface: the control-unit block that turns byte-addressed load/store requests (RV32 funct3 sizes) into MMU transactions.
- Drives CU_address, CU_bytesel, CU_dat_in, read_or_write and retrieve, using the MMU's fixed-latency timing.
- Performs lane alignment, load extraction and misalignment checking.
- Sits between the core's load/store path and the MMU.

---
 rtl/thetacore_mem_pkg.sv | 21 ++
 rtl/mmu_lane_align.sv | 82 ++++++++
 rtl/mmu_access_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/thetacore_mem_pkg.sv
// thetacore_mem_pkg
//   Shared definitions for the CU-side MMU access path:
//   - RV32 load/store funct3 size codes
//   - state encoding of the MMU access sequencer
package thetacore_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        WREC = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mmu_lane_align.sv
// mmu_lane_align
//   Purely combinational lane logic for the MMU word interface.
//   Ports:
//     write, funct3, off, wdata : request being offered (store alignment, error check)
//     ld_funct3, ld_off, word   : load in flight and the MMU word to extract from
//     bytesel, dat              : byte-lane enables and replicated write data
//     err                       : misaligned access or illegal funct3
//     rdata                     : extracted, sign/zero-extended load data
module mmu_lane_align
    import thetacore_mem_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] word,
    output logic [3:0]  bytesel,
    output logic [31:0] dat,
    output logic        err,
    output logic [31:0] rdata
);

    logic signed [7:0]  b_sel;
    logic signed [15:0] h_sel;
    logic signed [31:0] b_sx;
    logic signed [31:0] h_sx;

    // Loads always fetch the whole word; stores enable only the lanes written.
    always_comb begin
        bytesel = 4'b1111;
        dat     = 32'h0;
        if (write) begin
            case (funct3)
                F3_B: begin
                    bytesel = 4'b0001 << off;
                    dat     = {4{wdata[7:0]}};
                end
                F3_H: begin
                    bytesel = off[1] ? 4'b1100 : 4'b0011;
                    dat     = {2{wdata[15:0]}};
                end
                default: dat = wdata;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            F3_B, F3_BU: err = 1'b0;
            F3_H, F3_HU: err = off[0];
            F3_W:        err = (off != 2'b00);
            default:     err = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (write && funct3[2]) begin
            err = 1'b1;
        end
    end

    always_comb begin
        case (ld_off)
            2'd0:    b_sel = word[7:0];
            2'd1:    b_sel = word[15:8];
            2'd2:    b_sel = word[23:16];
            default: b_sel = word[31:24];
        endcase
        h_sel = ld_off[1] ? word[31:16] : word[15:0];
        // Signed-to-signed assignment performs the sign extension.
        b_sx  = b_sel;
        h_sx  = h_sel;
        case (ld_funct3)
            F3_B:    rdata = b_sx;
            F3_BU:   rdata = {24'h0, b_sel};
            F3_H:    rdata = h_sx;
            F3_HU:   rdata = {16'h0, h_sel};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/mmu_access_ctrl.sv
// mmu_access_ctrl
//   CU-side initiator for the fixed-latency MMU word interface. Accepts one
//   byte-addressed load/store at a time, drives the MMU strobes for the
//   configured number of cycles and returns a single-cycle completion.
//   Ports:
//     soc_clk, reset                : clock, synchronous active-low reset
//     req_*                         : request handshake and payload
//     resp_valid/resp_err/resp_rdata: completion pulse, error flag, load data
//     CU_address, CU_bytesel,
//     CU_dat_in, read_or_write,
//     retrieve                      : MMU command side
//     MMU_dat_out                   : MMU read word
module mmu_access_ctrl
    import thetacore_mem_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int RD_LAT     = 2,
    parameter int WR_HOLD    = 2,
    parameter int WR_RECOVER = 2
) (
    input  logic              soc_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] CU_address,
    output logic [3:0]        CU_bytesel,
    output logic [31:0]       CU_dat_in,
    output logic              read_or_write,
    output logic              retrieve,
    input  logic [31:0]       MMU_dat_out
);

    localparam int MAX_LAT = (RD_LAT > WR_HOLD)
                           ? ((RD_LAT  > WR_RECOVER) ? RD_LAT  : WR_RECOVER)
                           : ((WR_HOLD > WR_RECOVER) ? WR_HOLD : WR_RECOVER);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    if (RD_LAT < 1 || WR_HOLD < 1 || WR_RECOVER < 1) begin : g_bad_latency
        $error("mmu_access_ctrl: RD_LAT, WR_HOLD and WR_RECOVER must all be >= 1");
    end

    state_t             state_q;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next;
    logic               rst_done_q;
    logic [2:0]         ld_f3_q;
    logic [1:0]         ld_off_q;
    logic               accept;

    logic [3:0]         al_bytesel;
    logic [31:0]        al_dat;
    logic               al_err;
    logic [31:0]        al_rdata;

    mmu_lane_align u_align (
        .write     (req_write),
        .funct3    (req_funct3),
        .off       (req_addr[1:0]),
        .wdata     (req_wdata),
        .ld_funct3 (ld_f3_q),
        .ld_off    (ld_off_q),
        .word      (MMU_dat_out),
        .bytesel   (al_bytesel),
        .dat       (al_dat),
        .err       (al_err),
        .rdata     (al_rdata)
    );

    // rst_done_q keeps req_ready low for the first cycle after reset release.
    assign accept = req_valid && (state_q == IDLE) && rst_done_q;

    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        req_ready  = 1'b0;
        retrieve   = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rst_done_q;
                if (accept) begin
                    if (al_err) begin
                        state_next = DONE;
                    end else if (req_write) begin
                        state_next = WR;
                        cnt_next   = CNT_W'(WR_HOLD - 1);
                    end else begin
                        state_next = RD;
                        cnt_next   = CNT_W'(RD_LAT - 1);
                    end
                end
            end
            RD: begin
                retrieve = 1'b1;
                if (cnt_q == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            WR: begin
                retrieve = 1'b1;
                if (cnt_q == '0) begin
                    state_next = WREC;
                    cnt_next   = CNT_W'(WR_RECOVER - 1);
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            WREC: begin
                if (cnt_q == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
        end
    end

    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            rst_done_q    <= 1'b0;
            ld_f3_q       <= 3'b000;
            ld_off_q      <= 2'b00;
            CU_address    <= '0;
            CU_bytesel    <= 4'b0000;
            CU_dat_in     <= 32'h0;
            read_or_write <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= 32'h0;
        end else begin
            rst_done_q <= 1'b1;
            if (accept) begin
                ld_f3_q  <= req_funct3;
                ld_off_q <= req_addr[1:0];
                // Errored requests never reach the MMU, so the bus keeps its last command.
                if (!al_err) begin
                    CU_address    <= req_addr[ADDR_W+1:2];
                    CU_bytesel    <= al_bytesel;
                    CU_dat_in     <= al_dat;
                    read_or_write <= req_write;
                end else begin
                    resp_err   <= 1'b1;
                    resp_rdata <= 32'h0;
                end
            end
            // Response registers change only on the edge that enters DONE.
            if (state_q == RD && cnt_q == '0) begin
                resp_err   <= 1'b0;
                resp_rdata <= al_rdata;
            end
            if (state_q == WREC && cnt_q == '0) begin
                resp_err   <= 1'b0;
                resp_rdata <= 32'h0;
            end
        end
    end

endmodule
